// File: rtl/dino_pkg.sv
// Shared types and constants for the dino motion engine.
package dino_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    JUMP = 2'd1,
    DUCK = 2'd2,
    DEAD = 2'd3
  } pose_e;

  typedef logic [7:0]        coord_t;
  typedef logic signed [6:0] vel_t;

  localparam logic [9:0]  VACTIVE  = 10'd480;
  localparam int unsigned SPRITE_W = 32;
  localparam int unsigned SPRITE_H = 32;

endpackage

// File: rtl/frame_tick_gen.sv
// Emits a one-cycle tick on the first line of vertical blanking.
module frame_tick_gen
  import dino_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vcount,
  output logic       tick
);

  logic vblank;
  logic vblank_q;

  assign vblank = (vcount >= VACTIVE);

  always_ff @(posedge clk) begin
    if (reset) vblank_q <= 1'b0;
    else       vblank_q <= vblank;
  end

  assign tick = vblank & ~vblank_q;

endmodule

// File: rtl/dino_motion_engine.sv
// Per-frame dino jump/duck physics and cactus scroll feeding the sprite renderer.
// Optional AABB collision detection is enabled by defining COLLISION_DETECT_EN.
module dino_motion_engine
  import dino_pkg::*;
#(
  parameter coord_t     GROUND_Y      = 8'd100,
  parameter coord_t     DINO_X        = 8'd100,
  parameter logic [5:0] JUMP_V0       = 6'd12,
  parameter logic [5:0] GRAVITY       = 6'd1,
  parameter coord_t     CAC_SPEED     = 8'd4,
  parameter coord_t     CAC_RESPAWN_X = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vcount,
  input  logic       jump_req,
  input  logic       duck_req,
  input  logic       pause,
  output logic [7:0] dino_x,
  output logic [7:0] dino_y,
  output logic [1:0] pose,
  output logic [7:0] s_cac_x,
  output logic [7:0] s_cac_y,
  output logic       update_valid,
  output logic       game_over
);

  logic       tick;
  logic       advance;
  logic       jump_now;
  logic       jump_pend_q;
  logic       upd_q;
  pose_e      state_q, state_mv, state_d;
  coord_t     y_q, y_d;
  coord_t     cx_q, cx_d;
  vel_t       vel_q, vel_d;
  logic [8:0] y_step;

  frame_tick_gen u_tick (
    .clk    (clk),
    .reset  (reset),
    .vcount (vcount),
    .tick   (tick)
  );

  assign advance = tick & ~pause & (state_q != DEAD);

  always_comb begin
    jump_now = jump_pend_q | jump_req;
    y_step   = {1'b0, y_q} - {{2{vel_q[6]}}, vel_q};
    state_mv = state_q;
    y_d      = y_q;
    vel_d    = vel_q;
    cx_d     = ({1'b0, cx_q} < {1'b0, CAC_SPEED}) ? CAC_RESPAWN_X : cx_q - CAC_SPEED;
    case (state_q)
      RUN, DUCK: begin
        if (jump_now) begin
          // take-off applies the first velocity step in the same tick
          state_mv = JUMP;
          y_d      = y_q - {2'b00, JUMP_V0};
          vel_d    = $signed({1'b0, JUMP_V0}) - $signed({1'b0, GRAVITY});
        end else begin
          state_mv = duck_req ? DUCK : RUN;
        end
      end
      JUMP: begin
        if ($signed(y_step) >= $signed({1'b0, GROUND_Y})) begin
          state_mv = RUN;
          y_d      = GROUND_Y;
          vel_d    = '0;
        end else begin
          y_d      = y_step[7:0];
          vel_d    = vel_q - $signed({1'b0, GRAVITY});
        end
      end
      default: ;
    endcase
  end

`ifdef COLLISION_DETECT_EN
  logic       hit;
  logic       go_q;
  logic [8:0] d_left, d_right, d_top, d_bot;
  logic [8:0] c_left, c_right, c_top, c_bot;

  // overlap is judged on the positions about to be published
  always_comb begin
    d_left  = {1'b0, DINO_X};
    d_right = {1'b0, DINO_X} + 9'(SPRITE_W);
    d_top   = {1'b0, y_d} + ((state_mv == DUCK) ? 9'(SPRITE_H / 2) : 9'd0);
    d_bot   = {1'b0, y_d} + 9'(SPRITE_H);
    c_left  = {1'b0, cx_d};
    c_right = {1'b0, cx_d} + 9'(SPRITE_W);
    c_top   = {1'b0, GROUND_Y};
    c_bot   = {1'b0, GROUND_Y} + 9'(SPRITE_H);
    hit     = (d_left < c_right) && (c_left < d_right) &&
              (d_top < c_bot) && (c_top < d_bot);
  end

  assign state_d = hit ? DEAD : state_mv;

  always_ff @(posedge clk) begin
    if (reset)        go_q <= 1'b0;
    else if (advance) go_q <= go_q | hit;
  end

  assign game_over = go_q;
`else
  assign state_d   = state_mv;
  assign game_over = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      y_q         <= GROUND_Y;
      vel_q       <= '0;
      cx_q        <= CAC_RESPAWN_X;
      jump_pend_q <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      upd_q <= advance;
      if (tick)          jump_pend_q <= 1'b0;
      else if (jump_req) jump_pend_q <= 1'b1;
      if (advance) begin
        state_q <= state_d;
        y_q     <= y_d;
        vel_q   <= vel_d;
        cx_q    <= cx_d;
      end
    end
  end

  assign dino_x       = DINO_X;
  assign dino_y       = y_q;
  assign pose         = state_q;
  assign s_cac_x      = cx_q;
  assign s_cac_y      = GROUND_Y;
  assign update_valid = upd_q;

endmodule
